// File: rtl/enigma_pkg.sv
// Shared types and constants for the enigma port C sink.
package enigma_pkg;

  localparam int PAYLOAD_W = 128;
  localparam int ID_W      = 6;
  localparam int QOS_W     = 2;
  localparam int NUM_IDS   = 1 << ID_W;
  localparam int AGE_W     = 4;

  localparam logic [QOS_W-1:0] QOS_URGENT = 2'b11;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [ID_W-1:0]      id;
    logic [QOS_W-1:0]     qos;
  } flit_t;

endpackage

// File: rtl/enigma_c_sink_if.sv
// Port C (upstream flits, conflict/release feedback) and port D (drain)
// bundle. The slave modport is the sink's view; master is the environment.
interface enigma_c_sink_if;
  import enigma_pkg::*;

  logic                 valid_c;
  logic                 ready_c;
  logic [PAYLOAD_W-1:0] payload_c;
  logic [ID_W-1:0]      id_c;
  logic [QOS_W-1:0]     qos_c;
  logic                 conflict_c;
  logic                 release_c;
  logic [ID_W-1:0]      releaseid_c;
  logic                 valid_d;
  logic                 ready_d;
  logic [PAYLOAD_W-1:0] payload_d;
  logic [ID_W-1:0]      id_d;
  logic [QOS_W-1:0]     qos_d;
  logic [15:0]          conflict_cnt;

  modport slave (
    input  valid_c, payload_c, id_c, qos_c, ready_d,
    output ready_c, conflict_c, release_c, releaseid_c,
           valid_d, payload_d, id_d, qos_d, conflict_cnt
  );

  modport master (
    output valid_c, payload_c, id_c, qos_c, ready_d,
    input  ready_c, conflict_c, release_c, releaseid_c,
           valid_d, payload_d, id_d, qos_d, conflict_cnt
  );

endinterface

// File: rtl/enigma_id_scoreboard.sv
// In-flight id tracker: one busy bit per id. Lookup reads the registered
// vector, so a same-edge clear is never visible to the lookup.
module enigma_id_scoreboard
  import enigma_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] lookup_id,
  output logic            lookup_busy,
  input  logic            set_en,
  input  logic [ID_W-1:0] set_id,
  input  logic            clr_en,
  input  logic [ID_W-1:0] clr_id
);

  logic [NUM_IDS-1:0] busy_q, busy_d;

  assign lookup_busy = busy_q[lookup_id];

  // Next busy vector: set applied first so a clear to the same id wins.
  always_comb begin
    // NOTE: full default before any conditional update keeps this block latch-free.
    busy_d = busy_q;
    if (set_en) busy_d[set_id] = 1'b1;
    if (clr_en) busy_d[clr_id] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/enigma_c_sink.sv
// enigma_c_sink: accepts flits on port C, bounces id collisions, holds
// accepted flits in a FIFO for HOLD_CYCLES, drains them on port D and
// returns each drained id. Build option ENIGMA_QOS_BYPASS_EN makes
// urgent-qos entries ripe at age 0 (still strictly in FIFO order).
module enigma_c_sink
  import enigma_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input logic            clk,
  input logic            rst,
  enigma_c_sink_if.slave c_if
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [AGE_W-1:0] HOLD_AGE = AGE_W'(HOLD_CYCLES);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  flit_t            mem_q [DEPTH];
  flit_t            mem_d [DEPTH];
  logic [AGE_W-1:0] age_q [DEPTH];
  logic [AGE_W-1:0] age_d [DEPTH];
  logic             conflict_q, conflict_d;
  logic             release_q, release_d;
  logic [ID_W-1:0]  release_id_q, release_id_d;
  logic [15:0]      conflict_cnt_q, conflict_cnt_d;

  logic  ready_c, accept, id_busy, push, conflict_evt;
  logic  head_ripe, valid_d, pop;
  flit_t head, in_flit;

  // Handshake decode; everything here derives from registered state except
  // the accept/pop qualifiers, which only feed next-state logic.
  always_comb begin
    ready_c      = count_q < CNT_W'(DEPTH);
    accept       = c_if.valid_c & ready_c;
    push         = accept & ~id_busy;
    conflict_evt = accept & id_busy;
    head         = mem_q[rd_ptr_q];
`ifdef ENIGMA_QOS_BYPASS_EN
    head_ripe    = (age_q[rd_ptr_q] >= HOLD_AGE) || (head.qos == QOS_URGENT);
`else
    head_ripe    = age_q[rd_ptr_q] >= HOLD_AGE;
`endif
    valid_d      = (count_q != '0) & head_ripe;
    pop          = valid_d & c_if.ready_d;
    in_flit      = '{payload: c_if.payload_c, id: c_if.id_c, qos: c_if.qos_c};
  end

  enigma_id_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .lookup_id   (c_if.id_c),
    .lookup_busy (id_busy),
    .set_en      (push),
    .set_id      (c_if.id_c),
    .clr_en      (pop),
    .clr_id      (head.id)
  );

  // FIFO pointers, occupancy, entry ages/contents and feedback pulses.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + AGE_W'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = in_flit;
      age_d[wr_ptr_q] = '0;
    end
    conflict_d     = conflict_evt;
    release_d      = pop;
    release_id_d   = pop ? head.id : '0;
    conflict_cnt_d = conflict_cnt_q;
    if (conflict_evt && conflict_cnt_q != 16'hFFFF)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      conflict_q     <= 1'b0;
      release_q      <= 1'b0;
      release_id_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      conflict_q     <= conflict_d;
      release_q      <= release_d;
      release_id_q   <= release_id_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Entry storage and ages.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an empty count masks stale entries and push rewrites them.
    mem_q <= mem_d;
    age_q <= age_d;
  end

  // Port D shows zeros whenever no entry is offered.
  assign c_if.ready_c      = ready_c;
  assign c_if.valid_d      = valid_d;
  assign c_if.payload_d    = valid_d ? head.payload : '0;
  assign c_if.id_d         = valid_d ? head.id      : '0;
  assign c_if.qos_d        = valid_d ? head.qos     : '0;
  assign c_if.conflict_c   = conflict_q;
  assign c_if.release_c    = release_q;
  assign c_if.releaseid_c  = release_id_q;
  assign c_if.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_enigma_c_sink.sv
// Directed bench for enigma_c_sink (DEPTH=8, HOLD_CYCLES=4): a per-cycle
// vector table for the basic drain and collision flows, then hand-written
// sequences for full FIFO, pop/accept collision, reset and qos bypass.
module tb_enigma_c_sink;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  enigma_c_sink_if bus ();

  enigma_c_sink dut (
    .clk  (clk),
    .rst  (rst),
    .c_if (bus)
  );

  typedef struct {
    logic        vc;
    logic [5:0]  id;
    logic [1:0]  qos;
    logic        rd;
    logic        e_ready_c;
    logic        e_valid_d;
    logic [5:0]  e_id_d;
    logic        e_conflict;
    logic        e_release;
    logic [5:0]  e_relid;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic logic [127:0] pl(input logic [5:0] id);
    return {16{2'b10, id}};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vc, input logic [5:0] id, input logic [1:0] qos, input logic rd);
    bus.valid_c   = vc;
    bus.id_c      = id;
    bus.qos_c     = qos;
    bus.payload_c = pl(id);
    bus.ready_d   = rd;
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid_d();
    for (int i = 0; i < 40 && !bus.valid_d; i++) tick();
    check("wait_valid_d", bus.valid_d, 1'b1);
  endtask

  task automatic wait_release(input logic [5:0] exp_id);
    for (int i = 0; i < 40 && !bus.release_c; i++) tick();
    check("wait_release", bus.release_c, 1'b1);
    check("release_id", bus.releaseid_c, exp_id);
  endtask

  vec_t vecs [15];

  initial begin
    int k;
    int nrel;
    logic exp_vd;

    // ---- vector table: single flit drain, then id collision ----
    //          vc    id     qos   rd    rdyc  vld_d id_d   cnfl  rel   relid  cnt
    vecs[0]  = '{1'b1, 6'h05, 2'd0, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 16'd0};
    vecs[1]  = '{1'b0, 6'h00, 2'd0, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 16'd0};
    vecs[2]  = '{1'b0, 6'h00, 2'd0, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 16'd0};
    vecs[3]  = '{1'b0, 6'h00, 2'd0, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 16'd0};
    vecs[4]  = '{1'b0, 6'h00, 2'd0, 1'b1, 1'b1, 1'b1, 6'h05, 1'b0, 1'b0, 6'h00, 16'd0};
    vecs[5]  = '{1'b0, 6'h00, 2'd0, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 6'h05, 16'd0};
    vecs[6]  = '{1'b0, 6'h00, 2'd0, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 16'd0};
    vecs[7]  = '{1'b1, 6'h21, 2'd0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 16'd0};
    vecs[8]  = '{1'b1, 6'h21, 2'd0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 16'd1};
    vecs[9]  = '{1'b0, 6'h00, 2'd0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 16'd1};
    vecs[10] = '{1'b0, 6'h00, 2'd0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 16'd1};
    vecs[11] = '{1'b0, 6'h00, 2'd0, 1'b0, 1'b1, 1'b1, 6'h21, 1'b0, 1'b0, 6'h00, 16'd1};
    vecs[12] = '{1'b0, 6'h00, 2'd0, 1'b0, 1'b1, 1'b1, 6'h21, 1'b0, 1'b0, 6'h00, 16'd1};
    vecs[13] = '{1'b0, 6'h00, 2'd0, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 6'h21, 16'd1};
    vecs[14] = '{1'b0, 6'h00, 2'd0, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 16'd1};

    // ---- reset state ----
    drive(1'b0, 6'h00, 2'd0, 1'b0);
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ready_c", bus.ready_c, 1'b1);
    check("rst_valid_d", bus.valid_d, 1'b0);
    check("rst_conflict_c", bus.conflict_c, 1'b0);
    check("rst_release_c", bus.release_c, 1'b0);
    check("rst_conflict_cnt", bus.conflict_cnt, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].vc, vecs[i].id, vecs[i].qos, vecs[i].rd);
      tick();
      check($sformatf("v%0d_ready_c", i), bus.ready_c, vecs[i].e_ready_c);
      check($sformatf("v%0d_valid_d", i), bus.valid_d, vecs[i].e_valid_d);
      check($sformatf("v%0d_id_d", i), bus.id_d, vecs[i].e_id_d);
      if (vecs[i].e_valid_d)
        check($sformatf("v%0d_payload_d", i), bus.payload_d, pl(vecs[i].e_id_d));
      check($sformatf("v%0d_conflict_c", i), bus.conflict_c, vecs[i].e_conflict);
      check($sformatf("v%0d_release_c", i), bus.release_c, vecs[i].e_release);
      check($sformatf("v%0d_releaseid_c", i), bus.releaseid_c, vecs[i].e_relid);
      check($sformatf("v%0d_conflict_cnt", i), bus.conflict_cnt, vecs[i].e_cnt);
    end

    // ---- full FIFO: 8 ids, 9th refused, drain in order ----
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 6'h30 + 6'(i), 2'd0, 1'b0);
      tick();
      check($sformatf("full_ready_c_%0d", i), bus.ready_c, (i < 7) ? 1'b1 : 1'b0);
    end
    drive(1'b1, 6'h38, 2'd0, 1'b0);
    check("full_head_valid", bus.valid_d, 1'b1);
    check("full_head_id", bus.id_d, 6'h30);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_hold_ready_c", bus.ready_c, 1'b0);
      check("full_hold_payload", bus.payload_d, pl(6'h30));
      check("full_hold_conflict", bus.conflict_c, 1'b0);
    end
    drive(1'b0, 6'h00, 2'd0, 1'b1);
    k = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.release_c) begin
        if (k < 8) check($sformatf("drain_id_%0d", k), bus.releaseid_c, 6'h30 + 6'(k));
        k++;
      end
    end
    check("drain_count", k, 8);
    check("drain_empty", bus.valid_d, 1'b0);
    check("drain_cnt_kept", bus.conflict_cnt, 16'd1);

    // ---- pop of 6'h10 at the same edge as a new 6'h10 ----
    drive(1'b1, 6'h10, 2'd0, 1'b0);
    tick();
    drive(1'b0, 6'h00, 2'd0, 1'b0);
    wait_valid_d();
    check("pc_head_id", bus.id_d, 6'h10);
    drive(1'b1, 6'h10, 2'd0, 1'b1);
    tick();
    check("pc_conflict_c", bus.conflict_c, 1'b1);
    check("pc_release_c", bus.release_c, 1'b1);
    check("pc_releaseid_c", bus.releaseid_c, 6'h10);
    check("pc_conflict_cnt", bus.conflict_cnt, 16'd2);
    check("pc_empty", bus.valid_d, 1'b0);
    drive(1'b0, 6'h00, 2'd0, 1'b0);
    tick();
    check("pc_conflict_one_cycle", bus.conflict_c, 1'b0);
    check("pc_release_one_cycle", bus.release_c, 1'b0);
    drive(1'b1, 6'h10, 2'd0, 1'b1);
    tick();
    drive(1'b0, 6'h00, 2'd0, 1'b1);
    check("pc_busy_cleared", bus.conflict_c, 1'b0);
    wait_release(6'h10);

    // ---- reset with 3 entries resident ----
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'h11 + 6'(i), 2'd0, 1'b0);
      tick();
    end
    drive(1'b0, 6'h00, 2'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_ready_c", bus.ready_c, 1'b1);
    check("mr_valid_d", bus.valid_d, 1'b0);
    check("mr_payload_d", bus.payload_d, 128'd0);
    check("mr_id_d", bus.id_d, 6'h00);
    check("mr_conflict_c", bus.conflict_c, 1'b0);
    check("mr_release_c", bus.release_c, 1'b0);
    check("mr_releaseid_c", bus.releaseid_c, 6'h00);
    check("mr_conflict_cnt", bus.conflict_cnt, 16'd0);
    drive(1'b0, 6'h00, 2'd0, 1'b1);
    nrel = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.release_c) nrel++;
    end
    check("mr_no_release", nrel, 0);
    drive(1'b1, 6'h12, 2'd0, 1'b1);
    tick();
    drive(1'b0, 6'h00, 2'd0, 1'b1);
    check("mr_fresh_no_conflict", bus.conflict_c, 1'b0);
    wait_release(6'h12);

    // ---- urgent qos into an empty FIFO ----
    tick();
    drive(1'b1, 6'h2A, 2'b11, 1'b0);
    tick();
    drive(1'b0, 6'h00, 2'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
`ifdef ENIGMA_QOS_BYPASS_EN
      exp_vd = 1'b1;
`else
      exp_vd = (i >= 4);
`endif
      check($sformatf("qos_valid_d_%0d", i), bus.valid_d, exp_vd);
      if (i < 5) tick();
    end
    check("qos_qos_d", bus.qos_d, 2'b11);
    drive(1'b0, 6'h00, 2'd0, 1'b1);
    tick();
    check("qos_release_c", bus.release_c, 1'b1);
    check("qos_releaseid_c", bus.releaseid_c, 6'h2A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
